// File: rtl/sii9678_pkg.sv
// Shared definitions for the SiI9678 reset-pin pulse controller:
// register map, CTRL bit positions, FSM states and counter sizing.
package sii9678_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_WIDTH  = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_GO     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ABORT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GUARD  = 2'd2
    } state_t;

    // Bits needed to hold 0..n, never fewer than one.
    function automatic int cnt_bits(input int n);
        int b;
        b = $clog2(n + 1);
        return (b < 1) ? 1 : b;
    endfunction

endpackage

// File: rtl/sii9678_dncnt.sv
// Loadable down-counter that holds at zero and flags it.
module sii9678_dncnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sii9678_rst_pulse_out.sv
// Avalon-MM controller for the SiI9678 reset pin: static level or a
// hardware-timed pulse plus settle interval, with sticky DONE and maskable IRQ.
module sii9678_rst_pulse_out
    import sii9678_pkg::*;
#(
    parameter int   CNT_W         = 24,
    parameter logic IDLE_LEVEL    = 1'b1,
    parameter int   DEFAULT_WIDTH = 500000,
    parameter int   GUARD_CYCLES  = 2500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        out_port
);

    localparam int GW = cnt_bits(GUARD_CYCLES);
    localparam logic [GW-1:0] GUARD_LOAD = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    state_t             state, state_next;
    logic               data_reg, data_next;
    logic [CNT_W-1:0]   width_reg;
    logic               irq_en;
    logic               done;
    logic               out_next;
    logic [31:0]        rd_next;

    logic               wr, wr_data, wr_width, wr_ctrl, wr_status;
    logic               go_cmd, abort_cmd, busy;
    logic               pulse_load, guard_load, done_set;
    logic               pulse_zero, guard_zero;
    logic [CNT_W-1:0]   pulse_load_val;
    logic [CNT_W-1:0]   pulse_cnt_unused;
    logic [GW-1:0]      guard_cnt_unused;
    logic               unused_wdata;

    assign wr        = chipselect & ~write_n;
    assign wr_data   = wr && (address == ADDR_DATA);
    assign wr_width  = wr && (address == ADDR_WIDTH);
    assign wr_ctrl   = wr && (address == ADDR_CTRL);
    assign wr_status = wr && (address == ADDR_STATUS);
    assign abort_cmd = wr_ctrl & writedata[CTRL_ABORT];
    assign go_cmd    = wr_ctrl & writedata[CTRL_GO] & ~writedata[CTRL_ABORT];
    assign busy      = (state != ST_IDLE);
    assign unused_wdata = ^writedata;

    // WIDTH=0 is treated as a one-cycle pulse.
    assign pulse_load_val = (width_reg == '0) ? '0 : width_reg - 1'b1;

    sii9678_dncnt #(.W(CNT_W)) u_pulse_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (pulse_load),
        .load_val (pulse_load_val),
        .en       (state == ST_ASSERT),
        .count    (pulse_cnt_unused),
        .zero     (pulse_zero)
    );

    sii9678_dncnt #(.W(GW)) u_guard_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (guard_load),
        .load_val (GUARD_LOAD),
        .en       (state == ST_GUARD),
        .count    (guard_cnt_unused),
        .zero     (guard_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        pulse_load = 1'b0;
        guard_load = 1'b0;
        done_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go_cmd) begin
                    state_next = ST_ASSERT;
                    pulse_load = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (abort_cmd) begin
                    state_next = ST_IDLE;
                end else if (pulse_zero) begin
                    if (GUARD_CYCLES > 0) begin
                        state_next = ST_GUARD;
                        guard_load = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        done_set   = 1'b1;
                    end
                end
            end
            ST_GUARD: begin
                if (abort_cmd) begin
                    state_next = ST_IDLE;
                end else if (guard_zero) begin
                    state_next = ST_IDLE;
                    done_set   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Pin level follows the DATA value being written this cycle, so changes land next cycle.
    always_comb begin
        data_next = wr_data ? writedata[0] : data_reg;
        out_next  = (state_next == ST_ASSERT) ? ~data_next : data_next;
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:   rd_next[0] = data_reg;
            ADDR_WIDTH:  rd_next[CNT_W-1:0] = width_reg;
            ADDR_CTRL: begin
                rd_next[0] = busy;
                rd_next[1] = irq_en;
            end
            ADDR_STATUS: rd_next[0] = done;
            default:     rd_next = '0;
        endcase
    end

    // Completion beats a same-cycle STATUS clear so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg  <= IDLE_LEVEL;
            width_reg <= CNT_W'(DEFAULT_WIDTH);
            irq_en    <= 1'b0;
            done      <= 1'b0;
            out_port  <= IDLE_LEVEL;
            readdata  <= '0;
        end else begin
            data_reg <= data_next;
            out_port <= out_next;
            readdata <= rd_next;
            if (wr_width)
                width_reg <= writedata[CNT_W-1:0];
            if (wr_ctrl)
                irq_en <= writedata[CTRL_IRQ_EN];
            if (done_set)
                done <= 1'b1;
            else if (wr_status)
                done <= 1'b0;
        end
    end

    assign irq = done & irq_en;

endmodule
